// File: rtl/mdv_ctrl.sv
// mdv_ctrl: microdrive select controller between the ZX8302 peripheral logic and up to
// NDRIVES microdrive replay units. Decodes the serial drive-select chain, selects one
// drive, models motor spin-up and muxes the selected drive's gap/rx_ready/byte to the CPU.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   ce                CPU clock enable; spin-up counts only on ce
//   sel_clk/sel_data  drive-select chain clock level (async) and data bit
//   irq_ack           single-cycle clear of gap_irq
//   drv_gap/drv_rx_ready/drv_dout  per-drive status and byte (drive i at [8i+7:8i])
//   drv_sel           one-hot drive select
//   motor_on          high while spinning up or running
//   gap/rx_ready/dout CPU-visible registered status and byte
//   gap_irq           latched gap-start interrupt
//   sel_err           select chain holds more than one set bit
module mdv_ctrl #(
   parameter int unsigned NDRIVES      = 2,
   parameter int unsigned SPINUP_TICKS = 1500
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ce,
   input  logic                 sel_clk,
   input  logic                 sel_data,
   input  logic                 irq_ack,
   input  logic [NDRIVES-1:0]   drv_gap,
   input  logic [NDRIVES-1:0]   drv_rx_ready,
   input  logic [8*NDRIVES-1:0] drv_dout,
   output logic [NDRIVES-1:0]   drv_sel,
   output logic                 motor_on,
   output logic                 gap,
   output logic                 rx_ready,
   output logic [7:0]           dout,
   output logic                 gap_irq,
   output logic                 sel_err
);

   localparam int unsigned IdxW     = (NDRIVES > 1) ? $clog2(NDRIVES) : 1;
   localparam int unsigned CntW     = (SPINUP_TICKS > 0) ? $clog2(SPINUP_TICKS + 1) : 1;
   localparam int unsigned LastTick = (SPINUP_TICKS > 0) ? SPINUP_TICKS - 1 : 0;
   localparam logic [CntW-1:0] CntLast = CntW'(LastTick);

   typedef enum logic [1:0] {StIdle, StSpinup, StRun} state_e;

   function automatic logic [NDRIVES-1:0] onehot(input logic [IdxW-1:0] idx);
      logic [NDRIVES-1:0] v;
      v = '0;
      for (int i = 0; i < NDRIVES; i++) begin
         v[i] = (idx == IdxW'(i));
      end
      return v;
   endfunction

   // ---------------------------------------------------------------
   // sel_clk synchronizer and select shift register
   // ---------------------------------------------------------------
   logic               s1, s2, s3;
   logic               sel_edge;
   logic [NDRIVES-1:0] sr, sr_next;

   assign sel_edge = s2 & ~s3;

   // Written as a loop so NDRIVES=1 degenerates to sr <= sel_data.
   always_comb begin
      sr_next    = '0;
      sr_next[0] = sel_data;
      for (int i = 1; i < NDRIVES; i++) begin
         sr_next[i] = sr[i-1];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
         sr <= '0;
      end else begin
         s1 <= sel_clk;
         s2 <= s1;
         s3 <= s2;
         if (sel_edge) begin
            sr <= sr_next;
         end
      end
   end

   // ---------------------------------------------------------------
   // Registered decode of the shift register
   // ---------------------------------------------------------------
   logic [3:0]      ones;
   logic [IdxW-1:0] hot_idx;
   logic            tgt_valid;
   logic [IdxW-1:0] tgt_idx;

   always_comb begin
      ones    = '0;
      hot_idx = '0;
      for (int i = 0; i < NDRIVES; i++) begin
         if (sr[i]) begin
            ones    = ones + 4'd1;
            hot_idx = IdxW'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tgt_valid <= 1'b0;
         tgt_idx   <= '0;
         sel_err   <= 1'b0;
      end else begin
         tgt_valid <= (ones == 4'd1);
         tgt_idx   <= hot_idx;
         sel_err   <= (ones > 4'd1);
      end
   end

   // ---------------------------------------------------------------
   // Select / spin-up state machine
   // ---------------------------------------------------------------
   state_e          state;
   logic [IdxW-1:0] cur;
   logic [CntW-1:0] cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= StIdle;
         cur      <= '0;
         cnt      <= '0;
         drv_sel  <= '0;
         motor_on <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (tgt_valid) begin
                  state    <= StSpinup;
                  cur      <= tgt_idx;
                  cnt      <= '0;
                  drv_sel  <= onehot(tgt_idx);
                  motor_on <= 1'b1;
               end
            end
            StSpinup: begin
               if (!tgt_valid) begin
                  state    <= StIdle;
                  drv_sel  <= '0;
                  motor_on <= 1'b0;
               end else if (tgt_idx != cur) begin
                  cur     <= tgt_idx;
                  cnt     <= '0;
                  drv_sel <= onehot(tgt_idx);
               end else if (SPINUP_TICKS == 0) begin
                  state <= StRun;
               end else if (ce) begin
                  // cnt stops at CntLast, so it can never wrap
                  if (cnt == CntLast) begin
                     state <= StRun;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            StRun: begin
               if (!tgt_valid) begin
                  state    <= StIdle;
                  drv_sel  <= '0;
                  motor_on <= 1'b0;
               end else if (tgt_idx != cur) begin
                  state   <= StSpinup;
                  cur     <= tgt_idx;
                  cnt     <= '0;
                  drv_sel <= onehot(tgt_idx);
               end
            end
            default: begin
               state    <= StIdle;
               drv_sel  <= '0;
               motor_on <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Drive multiplexer and CPU-side registered outputs
   // ---------------------------------------------------------------
   logic       sel_gap, sel_rdy;
   logic [7:0] sel_dout;
   logic       in_run;
   logic       gap_prev;  // gap one clk earlier
   logic       gap_run;   // gap was last loaded from a drive, not forced

   assign in_run = (state == StRun);

   always_comb begin
      sel_gap  = 1'b1;
      sel_rdy  = 1'b0;
      sel_dout = '0;
      for (int i = 0; i < NDRIVES; i++) begin
         if (cur == IdxW'(i)) begin
            sel_gap  = drv_gap[i];
            sel_rdy  = drv_rx_ready[i];
            sel_dout = drv_dout[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gap      <= 1'b1;
         gap_prev <= 1'b1;
         gap_run  <= 1'b0;
         rx_ready <= 1'b0;
         dout     <= 8'h00;
         gap_irq  <= 1'b0;
      end else begin
         gap      <= in_run ? sel_gap : 1'b1;
         gap_prev <= gap;
         gap_run  <= in_run;
         rx_ready <= in_run & sel_rdy;
         if (in_run) begin
            dout <= sel_dout;
         end
         // A rise caused by leaving RUN is forced, not a gap start: gap_run masks it.
         if (gap & ~gap_prev & gap_run) begin
            gap_irq <= 1'b1;
         end else if (irq_ack) begin
            gap_irq <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mdv_ctrl.sv
module tb_mdv_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic        sel_clk;
   logic        sel_data;
   logic        irq_ack;
   logic [1:0]  drv_gap;
   logic [1:0]  drv_rx_ready;
   logic [15:0] drv_dout;
   logic [1:0]  drv_sel;
   logic        motor_on;
   logic        gap;
   logic        rx_ready;
   logic [7:0]  dout;
   logic        gap_irq;
   logic        sel_err;

   int checks = 0;
   int errors = 0;

   mdv_ctrl #(
      .NDRIVES      (2),
      .SPINUP_TICKS (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ce           (ce),
      .sel_clk      (sel_clk),
      .sel_data     (sel_data),
      .irq_ack      (irq_ack),
      .drv_gap      (drv_gap),
      .drv_rx_ready (drv_rx_ready),
      .drv_dout     (drv_dout),
      .drv_sel      (drv_sel),
      .motor_on     (motor_on),
      .gap          (gap),
      .rx_ready     (rx_ready),
      .dout         (dout),
      .gap_irq      (gap_irq),
      .sel_err      (sel_err)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // sel_clk rises just after edge k-1; returns just after edge k+3.
   task automatic pulse(input logic d);
      sel_data = d;
      sel_clk  = 1'b1;
      tick(3);
      sel_clk  = 1'b0;
      tick(1);
   endtask

   initial begin
      reset        = 1'b1;
      ce           = 1'b1;
      sel_clk      = 1'b0;
      sel_data     = 1'b0;
      irq_ack      = 1'b0;
      drv_gap      = 2'b00;
      drv_rx_ready = 2'b00;
      drv_dout     = 16'h0000;

      // Reset state
      tick(3);
      check("rst_drv_sel", drv_sel, 2'b00);
      check("rst_motor_on", motor_on, 1'b0);
      check("rst_gap", gap, 1'b1);
      check("rst_rx_ready", rx_ready, 1'b0);
      check("rst_dout", dout, 8'h00);
      check("rst_gap_irq", gap_irq, 1'b0);
      check("rst_sel_err", sel_err, 1'b0);
      reset = 1'b0;
      tick(2);

      // Select drive 0: drv_sel appears at k+4, not earlier
      pulse(1'b1);
      check("d0_sel_k3", drv_sel, 2'b00);
      check("d0_motor_k3", motor_on, 1'b0);
      tick(1);
      check("d0_sel_k4", drv_sel, 2'b01);
      check("d0_motor_k4", motor_on, 1'b1);
      // RUN is entered on the 4th ce edge; gap follows drive only one clk later
      tick(4);
      check("d0_spin_gap", gap, 1'b1);
      tick(1);
      check("d0_run_gap0", gap, 1'b0);

      // Gap rise -> gap one clk later, gap_irq one further
      drv_gap = 2'b01;
      tick(1);
      check("d0_gap_rise", gap, 1'b1);
      check("d0_irq_pre", gap_irq, 1'b0);
      tick(1);
      check("d0_irq_set", gap_irq, 1'b1);
      // New rising gap with irq_ack in the same cycle: set wins
      drv_gap = 2'b00;
      tick(1);
      drv_gap = 2'b01;
      tick(1);
      irq_ack = 1'b1;
      tick(1);
      irq_ack = 1'b0;
      check("irq_set_wins", gap_irq, 1'b1);
      // irq_ack alone clears
      irq_ack = 1'b1;
      tick(1);
      irq_ack = 1'b0;
      check("irq_ack_clr", gap_irq, 1'b0);

      // rx_ready pulse from the selected drive
      drv_gap      = 2'b00;
      drv_dout     = 16'h3CA5;
      drv_rx_ready = 2'b01;
      tick(1);
      drv_rx_ready = 2'b00;
      check("d0_rx_pulse", rx_ready, 1'b1);
      check("d0_dout", dout, 8'hA5);
      tick(1);
      check("d0_rx_end", rx_ready, 1'b0);
      // Pulse on the unselected drive is ignored
      drv_rx_ready = 2'b10;
      tick(1);
      drv_rx_ready = 2'b00;
      check("d1_rx_ignored", rx_ready, 1'b0);
      check("d0_dout_hold", dout, 8'hA5);

      // Shift a 0: sr=10, spin-up restarts on drive 1
      pulse(1'b0);
      check("d1_sel_k3", drv_sel, 2'b01);
      tick(1);
      check("d1_sel_k4", drv_sel, 2'b10);
      check("d1_motor", motor_on, 1'b1);
      // ce held low for two clocks delays RUN by two clocks
      ce = 1'b0;
      tick(2);
      ce = 1'b1;
      tick(4);
      check("d1_spin_gap", gap, 1'b1);
      check("d1_forced_no_irq", gap_irq, 1'b0);
      tick(1);
      check("d1_run_gap0", gap, 1'b0);
      drv_gap      = 2'b01;
      drv_rx_ready = 2'b10;
      tick(1);
      drv_rx_ready = 2'b00;
      check("d1_gap_mux", gap, 1'b0);
      check("d1_rx_pulse", rx_ready, 1'b1);
      check("d1_dout", dout, 8'h3C);
      drv_gap = 2'b10;
      tick(2);
      check("d1_irq_set", gap_irq, 1'b1);

      // Shift 1 twice: sr=01 then sr=11 -> error, IDLE
      pulse(1'b1);
      tick(1);
      check("err_first_sel", drv_sel, 2'b01);
      pulse(1'b1);
      check("err_sel_err", sel_err, 1'b1);
      tick(1);
      check("err_drv_sel", drv_sel, 2'b00);
      check("err_motor", motor_on, 1'b0);
      tick(1);
      check("err_gap", gap, 1'b1);
      check("err_rx_ready", rx_ready, 1'b0);

      // Shift 0: sr=10 -> spin-up drive 1, then async reset mid-cycle
      pulse(1'b0);
      tick(1);
      check("rs_sel_spin", drv_sel, 2'b10);
      check("rs_irq_held", gap_irq, 1'b1);
      #1;
      reset = 1'b1;
      #2;
      check("rs_drv_sel", drv_sel, 2'b00);
      check("rs_motor", motor_on, 1'b0);
      check("rs_gap", gap, 1'b1);
      check("rs_gap_irq", gap_irq, 1'b0);
      check("rs_sel_err", sel_err, 1'b0);
      tick(2);
      reset = 1'b0;
      tick(6);
      check("rs_shift_lost", drv_sel, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
